// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store bus controller between the core memory stage and
// the data-memory bank / IO peripheral. One request at a time; decodes the
// region, checks alignment and funct legality, then runs either a single-cycle
// bank strobe or an IO setup/access transaction with wait states and timeout.
//
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_lsu_req/we/addr/wdata/funct        request from the core (taken in IDLE)
//   o_lsu_busy/done/rdata/misalign/fault completion and status to the core
//   po_lsu_addr, penable_o, pwrite_o,
//   pwdata_o, pfunct_code_o, prdata_i    data-memory bank port
//   pio_sel_o, pio_enable_o, pio_write_o,
//   pio_addr_o, pio_wdata_o,
//   pio_rdata_i, pio_ready_i             IO peripheral port
module lsu_bus_ctrl #(
  parameter int unsigned DMEM_ADDR = 13,
  parameter logic [31:0] IO_BASE   = 32'h1000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_lsu_req,
  input  logic                 i_lsu_we,
  input  logic [31:0]          i_lsu_addr,
  input  logic [31:0]          i_lsu_wdata,
  input  logic [2:0]           i_lsu_funct,
  output logic                 o_lsu_busy,
  output logic                 o_lsu_done,
  output logic [31:0]          o_lsu_rdata,
  output logic                 o_lsu_misalign,
  output logic                 o_lsu_fault,
  output logic [DMEM_ADDR-1:0] po_lsu_addr,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [31:0]          pwdata_o,
  output logic [2:0]           pfunct_code_o,
  input  logic [31:0]          prdata_i,
  output logic                 pio_sel_o,
  output logic                 pio_enable_o,
  output logic                 pio_write_o,
  output logic [7:0]           pio_addr_o,
  output logic [31:0]          pio_wdata_o,
  input  logic [31:0]          pio_rdata_i,
  input  logic                 pio_ready_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DMEM      = 3'd1,
    S_IO_SETUP  = 3'd2,
    S_IO_ACCESS = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [DMEM_ADDR-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [2:0]           funct_q, funct_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 misalign_q, misalign_d;
  logic                 fault_q, fault_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [DMEM_ADDR-1:0] paddr_q, paddr_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic [2:0]           pfunct_q, pfunct_d;
  logic                 io_sel_q, io_sel_d;
  logic                 io_en_q, io_en_d;
  logic                 io_wr_q, io_wr_d;
  logic [7:0]           io_addr_q, io_addr_d;
  logic [31:0]          io_wdata_q, io_wdata_d;

  // Request classification, only consumed when accepting in IDLE.
  logic req_misalign, req_illegal, req_dmem, req_io;

  always_comb begin
    req_misalign = ((i_lsu_funct[1:0] == 2'b01) && i_lsu_addr[0]) ||
                   ((i_lsu_funct[1:0] == 2'b10) && (i_lsu_addr[1:0] != 2'b00));
    req_illegal  = i_lsu_we ? (i_lsu_funct > 3'd2)
                            : ((i_lsu_funct == 3'd3) || (i_lsu_funct == 3'd6) ||
                               (i_lsu_funct == 3'd7));
    req_dmem     = (i_lsu_addr[31:DMEM_ADDR] == '0);
    req_io       = (i_lsu_addr[31:8] == IO_BASE[31:8]);
  end

  // Next state, payload capture and result update.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    funct_d    = funct_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    fault_d    = fault_q;

    case (state_q)
      S_IDLE: begin
        if (i_lsu_req) begin
          addr_d     = i_lsu_addr[DMEM_ADDR-1:0];
          we_d       = i_lsu_we;
          wdata_d    = i_lsu_wdata;
          funct_d    = i_lsu_funct;
          cnt_d      = '0;
          rdata_d    = '0;
          misalign_d = 1'b0;
          fault_d    = 1'b0;
          if (req_misalign) begin
            misalign_d = 1'b1;
            state_d    = S_DONE;
          end else if (req_illegal || (req_io && (i_lsu_funct != 3'b010)) ||
                       (!req_io && !req_dmem)) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else if (req_dmem) begin
            state_d = S_DMEM;
          end else begin
            state_d = S_IO_SETUP;
          end
        end
      end
      S_DMEM: begin
        if (!we_q) rdata_d = prdata_i;
        state_d = S_DONE;
      end
      S_IO_SETUP: begin
        cnt_d   = CNT_W'(1);
        state_d = S_IO_ACCESS;
      end
      S_IO_ACCESS: begin
        if (pio_ready_i) begin
          if (!we_q) rdata_d = pio_rdata_i;
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          fault_d = 1'b1;
          rdata_d = '0;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output register inputs decoded from the upcoming state, so every output
  // is a flop and bus strobes never overlap.
  always_comb begin
    busy_d     = (state_d == S_DMEM) || (state_d == S_IO_SETUP) ||
                 (state_d == S_IO_ACCESS);
    done_d     = (state_d == S_DONE);
    penable_d  = 1'b0;
    pwrite_d   = 1'b0;
    paddr_d    = '0;
    pwdata_d   = '0;
    pfunct_d   = '0;
    io_sel_d   = 1'b0;
    io_en_d    = 1'b0;
    io_wr_d    = 1'b0;
    io_addr_d  = '0;
    io_wdata_d = '0;
    if (state_d == S_DMEM) begin
      penable_d = 1'b1;
      pwrite_d  = we_d;
      paddr_d   = addr_d;
      pwdata_d  = wdata_d;
      pfunct_d  = funct_d;
    end
    if ((state_d == S_IO_SETUP) || (state_d == S_IO_ACCESS)) begin
      io_sel_d   = 1'b1;
      io_en_d    = (state_d == S_IO_ACCESS);
      io_wr_d    = we_d;
      io_addr_d  = addr_d[7:0];
      io_wdata_d = wdata_d;
    end
  end

  // State, payload and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      funct_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pfunct_q   <= '0;
      io_sel_q   <= 1'b0;
      io_en_q    <= 1'b0;
      io_wr_q    <= 1'b0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      funct_q    <= funct_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pfunct_q   <= pfunct_d;
      io_sel_q   <= io_sel_d;
      io_en_q    <= io_en_d;
      io_wr_q    <= io_wr_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
    end
  end

  assign o_lsu_busy     = busy_q;
  assign o_lsu_done     = done_q;
  assign o_lsu_rdata    = rdata_q;
  assign o_lsu_misalign = misalign_q;
  assign o_lsu_fault    = fault_q;
  assign po_lsu_addr    = paddr_q;
  assign penable_o      = penable_q;
  assign pwrite_o       = pwrite_q;
  assign pwdata_o       = pwdata_q;
  assign pfunct_code_o  = pfunct_q;
  assign pio_sel_o      = io_sel_q;
  assign pio_enable_o   = io_en_q;
  assign pio_write_o    = io_wr_q;
  assign pio_addr_o     = io_addr_q;
  assign pio_wdata_o    = io_wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl with a behavioural data-memory bank and a
// scripted IO responder.
module tb_lsu_bus_ctrl;

  localparam int unsigned DMEM_ADDR = 13;
  localparam logic [31:0] IO_BASE   = 32'h1000_0000;
  localparam int unsigned TIMEOUT   = 16;
  localparam int          BUDGET    = 100;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_lsu_req = 1'b0;
  logic                 i_lsu_we = 1'b0;
  logic [31:0]          i_lsu_addr = '0;
  logic [31:0]          i_lsu_wdata = '0;
  logic [2:0]           i_lsu_funct = '0;
  logic                 o_lsu_busy, o_lsu_done, o_lsu_misalign, o_lsu_fault;
  logic [31:0]          o_lsu_rdata;
  logic [DMEM_ADDR-1:0] po_lsu_addr;
  logic                 penable_o, pwrite_o;
  logic [31:0]          pwdata_o;
  logic [2:0]           pfunct_code_o;
  logic [31:0]          prdata_i;
  logic                 pio_sel_o, pio_enable_o, pio_write_o;
  logic [7:0]           pio_addr_o;
  logic [31:0]          pio_wdata_o;
  logic [31:0]          pio_rdata_i = '0;
  logic                 pio_ready_i = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.DMEM_ADDR(DMEM_ADDR), .IO_BASE(IO_BASE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_lsu_req(i_lsu_req), .i_lsu_we(i_lsu_we), .i_lsu_addr(i_lsu_addr),
    .i_lsu_wdata(i_lsu_wdata), .i_lsu_funct(i_lsu_funct),
    .o_lsu_busy(o_lsu_busy), .o_lsu_done(o_lsu_done), .o_lsu_rdata(o_lsu_rdata),
    .o_lsu_misalign(o_lsu_misalign), .o_lsu_fault(o_lsu_fault),
    .po_lsu_addr(po_lsu_addr), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pfunct_code_o(pfunct_code_o), .prdata_i(prdata_i),
    .pio_sel_o(pio_sel_o), .pio_enable_o(pio_enable_o), .pio_write_o(pio_write_o),
    .pio_addr_o(pio_addr_o), .pio_wdata_o(pio_wdata_o),
    .pio_rdata_i(pio_rdata_i), .pio_ready_i(pio_ready_i)
  );

  // Every DUT output concatenated; must be all zero in reset.
  logic [131:0] all_out;
  assign all_out = {o_lsu_busy, o_lsu_done, o_lsu_rdata, o_lsu_misalign, o_lsu_fault,
                    penable_o, pwrite_o, pwdata_o, po_lsu_addr, pfunct_code_o,
                    pio_sel_o, pio_enable_o, pio_write_o, pio_addr_o, pio_wdata_o};

  // Bank model: 2K words, filled with C0DE_<index> on the first clock, formats
  // reads by funct/offset and writes byte/half/word lanes on the strobe edge.
  logic [31:0] mem [2048];
  bit          mem_ready = 1'b0;
  logic [31:0] bw, bsh, hsh;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      mem_ready <= 1'b1;
    end else if (penable_o && pwrite_o) begin
      case (pfunct_code_o)
        3'd0:    mem[po_lsu_addr[12:2]][{po_lsu_addr[1:0], 3'b000} +: 8] <= pwdata_o[7:0];
        3'd1:    mem[po_lsu_addr[12:2]][{po_lsu_addr[1], 4'b0000} +: 16] <= pwdata_o[15:0];
        default: mem[po_lsu_addr[12:2]] <= pwdata_o;
      endcase
    end
  end

  always_comb begin
    bw  = mem[po_lsu_addr[12:2]];
    bsh = bw >> {po_lsu_addr[1:0], 3'b000};
    hsh = bw >> {po_lsu_addr[1], 4'b0000};
    if (!penable_o) prdata_i = 32'hBAD0_BAD0;
    else case (pfunct_code_o)
      3'd0:    prdata_i = {{24{bsh[7]}}, bsh[7:0]};
      3'd4:    prdata_i = {24'h0, bsh[7:0]};
      3'd1:    prdata_i = {{16{hsh[15]}}, hsh[15:0]};
      3'd5:    prdata_i = {16'h0, hsh[15:0]};
      default: prdata_i = bw;
    endcase
  end

  // Transaction driver: issues one request, watches until done (bounded) and
  // reports latency plus bus activity. Returns at the negedge of the done cycle.
  int          r_done, r_pen, r_sel, r_en, r_busy;
  logic [31:0] r_rd;
  logic        r_mis, r_flt, r_ovl;
  logic [7:0]  r_paddr;

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] funct, input int ready_at, input logic [31:0] io_rd);
    @(negedge clk);
    i_lsu_req = 1'b1; i_lsu_we = we; i_lsu_addr = addr;
    i_lsu_wdata = wdata; i_lsu_funct = funct;
    pio_ready_i = 1'b0; pio_rdata_i = io_rd;
    r_done = -1; r_pen = 0; r_sel = 0; r_en = 0; r_busy = 0;
    r_rd = 'x; r_mis = 1'bx; r_flt = 1'bx; r_ovl = 1'b0; r_paddr = '0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      i_lsu_req = 1'b0;
      if (penable_o) r_pen++;
      if (pio_sel_o) begin r_sel++; r_paddr = pio_addr_o; end
      if (pio_enable_o) r_en++;
      if (o_lsu_busy) r_busy++;
      if (penable_o && pio_sel_o) r_ovl = 1'b1;
      if (o_lsu_done) begin
        r_done = c; r_rd = o_lsu_rdata; r_mis = o_lsu_misalign; r_flt = o_lsu_fault;
        break;
      end
      pio_ready_i = (c == ready_at);
    end
    pio_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL idle_outputs got=%h exp=0", all_out); end
  endtask

  task automatic test_dmem();
    run_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2, -1, '0);
    checks++;
    if (r_done !== 2 || r_pen !== 1 || r_busy !== 1) begin failures++;
      $display("FAIL sw_timing done=%0d pen=%0d busy=%0d exp 2/1/1", r_done, r_pen, r_busy); end
    checks++;
    if (r_rd !== 32'h0 || r_mis !== 1'b0 || r_flt !== 1'b0) begin failures++;
      $display("FAIL sw_result rd=%h mis=%b flt=%b exp 0/0/0", r_rd, r_mis, r_flt); end
    checks++;
    if (mem[4] !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL sw_bank got=%h exp=deadbeef", mem[4]); end
    run_txn(1'b0, 32'h10, '0, 3'd2, -1, '0);
    checks++;
    if (r_done !== 2 || r_pen !== 1 || r_rd !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL lw done=%0d pen=%0d rd=%h exp 2/1/deadbeef", r_done, r_pen, r_rd); end
    run_txn(1'b0, 32'h13, '0, 3'd0, -1, '0);
    checks++;
    if (r_rd !== 32'hFFFF_FFDE) begin failures++; $display("FAIL lb got=%h exp=ffffffde", r_rd); end
    run_txn(1'b0, 32'h13, '0, 3'd4, -1, '0);
    checks++;
    if (r_rd !== 32'h0000_00DE) begin failures++; $display("FAIL lbu got=%h exp=000000de", r_rd); end
    run_txn(1'b0, 32'h12, '0, 3'd1, -1, '0);
    checks++;
    if (r_rd !== 32'hFFFF_DEAD) begin failures++; $display("FAIL lh got=%h exp=ffffdead", r_rd); end
    @(negedge clk);
    checks++;
    if (o_lsu_done !== 1'b0 || o_lsu_rdata !== 32'hFFFF_DEAD) begin failures++;
      $display("FAIL lh_hold done=%b rd=%h exp 0/ffffdead", o_lsu_done, o_lsu_rdata); end
  endtask

  task automatic test_misalign();
    run_txn(1'b0, 32'h12, '0, 3'd2, -1, '0);
    checks++;
    if (r_done !== 1 || r_mis !== 1'b1 || r_flt !== 1'b0 || r_pen !== 0 || r_rd !== 32'h0) begin
      failures++;
      $display("FAIL lw_misalign done=%0d mis=%b flt=%b pen=%0d rd=%h exp 1/1/0/0/0",
               r_done, r_mis, r_flt, r_pen, r_rd); end
    run_txn(1'b1, 32'h11, 32'h1234, 3'd1, -1, '0);
    checks++;
    if (r_done !== 1 || r_mis !== 1'b1 || r_flt !== 1'b0 || r_pen !== 0) begin failures++;
      $display("FAIL sh_misalign done=%0d mis=%b flt=%b pen=%0d exp 1/1/0/0",
               r_done, r_mis, r_flt, r_pen); end
  endtask

  task automatic test_io();
    run_txn(1'b0, IO_BASE + 32'h4, '0, 3'd2, 4, 32'h5A);
    checks++;
    if (r_done !== 5 || r_sel !== 4 || r_en !== 3 || r_busy !== 4) begin failures++;
      $display("FAIL io_timing done=%0d sel=%0d en=%0d busy=%0d exp 5/4/3/4",
               r_done, r_sel, r_en, r_busy); end
    checks++;
    if (r_paddr !== 8'h04 || r_rd !== 32'h5A || r_flt !== 1'b0 || r_pen !== 0 || r_ovl !== 1'b0) begin
      failures++;
      $display("FAIL io_result paddr=%h rd=%h flt=%b pen=%0d ovl=%b exp 04/5a/0/0/0",
               r_paddr, r_rd, r_flt, r_pen, r_ovl); end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, IO_BASE, '0, 3'd2, -1, 32'h77);
    checks++;
    if (r_done !== 2 + TIMEOUT || r_en !== TIMEOUT) begin failures++;
      $display("FAIL timeout_timing done=%0d en=%0d exp %0d/%0d", r_done, r_en, 2 + TIMEOUT, TIMEOUT); end
    checks++;
    if (r_flt !== 1'b1 || r_rd !== 32'h0 || r_mis !== 1'b0) begin failures++;
      $display("FAIL timeout_result flt=%b rd=%h mis=%b exp 1/0/0", r_flt, r_rd, r_mis); end
  endtask

  task automatic test_faults();
    run_txn(1'b0, IO_BASE, '0, 3'd0, -1, '0);
    checks++;
    if (r_done !== 1 || r_flt !== 1'b1 || r_sel !== 0 || r_pen !== 0) begin failures++;
      $display("FAIL io_lb done=%0d flt=%b sel=%0d pen=%0d exp 1/1/0/0", r_done, r_flt, r_sel, r_pen); end
    run_txn(1'b0, 32'h8000_0000, '0, 3'd2, -1, '0);
    checks++;
    if (r_done !== 1 || r_flt !== 1'b1 || r_sel !== 0 || r_pen !== 0) begin failures++;
      $display("FAIL unmapped done=%0d flt=%b sel=%0d pen=%0d exp 1/1/0/0", r_done, r_flt, r_sel, r_pen); end
    run_txn(1'b0, 32'h10, '0, 3'd3, -1, '0);
    checks++;
    if (r_done !== 1 || r_flt !== 1'b1 || r_mis !== 1'b0 || r_pen !== 0) begin failures++;
      $display("FAIL ld_funct3 done=%0d flt=%b mis=%b pen=%0d exp 1/1/0/0", r_done, r_flt, r_mis, r_pen); end
    run_txn(1'b1, 32'h10, 32'h5555, 3'd4, -1, '0);
    checks++;
    if (r_done !== 1 || r_flt !== 1'b1 || r_pen !== 0 || mem[4] !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL st_funct4 done=%0d flt=%b pen=%0d mem=%h exp 1/1/0/deadbeef",
               r_done, r_flt, r_pen, mem[4]); end
    @(negedge clk);
    checks++;
    if (o_lsu_done !== 1'b0 || o_lsu_fault !== 1'b1) begin failures++;
      $display("FAIL fault_hold done=%b flt=%b exp 0/1", o_lsu_done, o_lsu_fault); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] pen_pat, done_pat;
    pen_pat = '0; done_pat = '0;
    @(negedge clk);
    i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 32'h10; i_lsu_funct = 3'd2;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      pen_pat[c-1]  = penable_o;
      done_pat[c-1] = o_lsu_done;
      if (c == 6) i_lsu_req = 1'b0;
    end
    checks++;
    if (pen_pat !== 7'b0001001) begin failures++;
      $display("FAIL b2b_penable got=%b exp=0001001", pen_pat); end
    checks++;
    if (done_pat !== 7'b0010010 || o_lsu_rdata !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL b2b_done got=%b rd=%h exp 0010010/deadbeef", done_pat, o_lsu_rdata); end
  endtask

  task automatic test_reset_mid();
    // Reset in the middle of a store strobe: outputs clear at once, no write.
    @(negedge clk);
    i_lsu_req = 1'b1; i_lsu_we = 1'b1; i_lsu_addr = 32'h20;
    i_lsu_wdata = 32'h1111_2222; i_lsu_funct = 3'd2;
    @(negedge clk);
    i_lsu_req = 1'b0;
    checks++;
    if (penable_o !== 1'b1 || pwrite_o !== 1'b1) begin failures++;
      $display("FAIL mid_dmem_strobe pen=%b wr=%b exp 1/1", penable_o, pwrite_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL rst_in_dmem got=%h exp=0", all_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 32'h20, '0, 3'd2, -1, '0);
    checks++;
    if (r_done !== 2 || r_rd !== 32'hC0DE_0008) begin failures++;
      $display("FAIL post_rst_lw20 done=%0d rd=%h exp 2/c0de0008", r_done, r_rd); end
    run_txn(1'b0, 32'h10, '0, 3'd2, -1, '0);
    checks++;
    if (r_done !== 2 || r_pen !== 1 || r_rd !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL post_rst_lw10 done=%0d pen=%0d rd=%h exp 2/1/deadbeef", r_done, r_pen, r_rd); end
    // Reset while in the IO access phase.
    @(negedge clk);
    i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = IO_BASE; i_lsu_funct = 3'd2;
    @(negedge clk);
    i_lsu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (pio_sel_o !== 1'b1 || pio_enable_o !== 1'b1 || o_lsu_busy !== 1'b1) begin failures++;
      $display("FAIL mid_io_access sel=%b en=%b busy=%b exp 1/1/1", pio_sel_o, pio_enable_o, o_lsu_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL rst_in_io got=%h exp=0", all_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL post_rst_idle got=%h exp=0", all_out); end
  endtask

  initial begin
    test_reset();
    test_dmem();
    test_misalign();
    test_io();
    test_timeout();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
